// File: rtl/rpsc_card_1.sv
// RPSC card 1: fan/alarm/CA-supply interlock glue logic with a cascaded
// 4 s / 60 s qualification delay before the CA supply is reported OK.

module timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             in,
    output logic             hit_target
);

    logic [WIDTH-1:0] r_count;

    // Counts consecutive edges with in=1, saturating at target so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || !in) begin
            r_count <= '0;
        end else if (r_count < target) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign hit_target = (r_count == target);

endmodule

module special_60s_timer #(
    parameter int test_mode = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic hit_target
);

    localparam int            W_60S = (test_mode != 0) ? 6 : 26;
    // 60 s at 781.25 kHz, or a short target for simulation.
    localparam logic [W_60S-1:0] T_60S = W_60S'((test_mode != 0) ? 60 : 46875000);

    timer #(
        .WIDTH (W_60S)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .target     (T_60S),
        .in         (in),
        .hit_target (hit_target)
    );

endmodule

module rpsc_card_1 #(
    parameter int test_mode = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i51_Card_POS,
    input  logic i50_Air_Grid,
    input  logic i49_Water_Anode,
    input  logic i48_Water_Grid,
    input  logic i46_DC_PS,
    input  logic i45_U_CA_Low,
    input  logic i44_I_CA_High,
    input  logic i53_Not_G1_OK,
    input  logic i54_FAN_ON,
    input  logic i59_CA_PS_ACT,
    input  logic i17_FAN_ON_PERM,
    input  logic i18_FAN_ACT,
    input  logic i72_I_CA_High,
    input  logic i76_U_CA_Low,
    output logic o19_FAN_ON,
    output logic o14_FAN_ON_PERM,
    output logic o55_Not_Alarm,
    output logic o47_CA_ON_PERM,
    output logic o62_CA_ON,
    output logic o74_CA_Delay,
    output logic o75_Not_CA_OK,
    output logic o70_I_CA_High,
    output logic o77_U_CA_Low,
    output logic o78_Modified
);

    localparam int            W_4S = (test_mode != 0) ? 4 : 22;
    // 4 s at 781.25 kHz, or a short target for simulation.
    localparam logic [W_4S-1:0] T_4S = W_4S'((test_mode != 0) ? 15 : 3125000);

    logic w_nor_status;
    logic w_nor_control;
    logic w_and_control;
    logic w_on_4s;
    logic w_on_60s;

    assign w_nor_status  = ~(i51_Card_POS | i50_Air_Grid | i49_Water_Anode | i48_Water_Grid |
                             i46_DC_PS | i45_U_CA_Low | i44_I_CA_High);
    assign w_nor_control = ~(i53_Not_G1_OK | i54_FAN_ON | ~w_nor_status);
    assign w_and_control = w_nor_control & i59_CA_PS_ACT;

    // Any interruption of the enable restarts the 4 s stage, and its drop in turn restarts the 60 s stage.
    timer #(
        .WIDTH (W_4S)
    ) u_timer_4s (
        .clk        (clk),
        .reset      (reset),
        .target     (T_4S),
        .in         (w_and_control),
        .hit_target (w_on_4s)
    );

    special_60s_timer #(
        .test_mode (test_mode)
    ) u_timer_60s (
        .clk        (clk),
        .reset      (reset),
        .in         (w_on_4s),
        .hit_target (w_on_60s)
    );

    assign o14_FAN_ON_PERM = ~i17_FAN_ON_PERM;
    assign o19_FAN_ON      = ~i18_FAN_ACT;
    assign o55_Not_Alarm   = w_nor_status;
    assign o78_Modified    = w_nor_control;
    assign o47_CA_ON_PERM  = ~w_nor_control;
    assign o62_CA_ON       = ~i59_CA_PS_ACT;
    assign o74_CA_Delay    = w_on_60s;
    assign o75_Not_CA_OK   = ~(w_on_4s & w_on_60s);
    assign o70_I_CA_High   = ~(w_on_4s & i72_I_CA_High);
    assign o77_U_CA_Low    = ~(w_on_4s & i76_U_CA_Low);

endmodule

// File: tb/tb_rpsc_card_1.sv
// Self-checking bench for rpsc_card_1 in test_mode (4 s -> 15 edges, 60 s -> 60 edges).

module tb_rpsc_card_1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    // {i51, i50, i49, i48, i46, i45, i44}
    logic [6:0] st = '0;
    // {i53, i54, i59, i17, i18, i72, i76}
    logic [6:0] ct = '0;

    logic o19, o14, o55, o47, o62, o74, o75, o70, o77, o78;
    logic [9:0] w_out;
    assign w_out = {o19, o14, o55, o47, o62, o78, o74, o75, o70, o77};

    always #5 clk = ~clk;

    rpsc_card_1 #(
        .test_mode (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i51_Card_POS    (st[6]),
        .i50_Air_Grid    (st[5]),
        .i49_Water_Anode (st[4]),
        .i48_Water_Grid  (st[3]),
        .i46_DC_PS       (st[2]),
        .i45_U_CA_Low    (st[1]),
        .i44_I_CA_High   (st[0]),
        .i53_Not_G1_OK   (ct[6]),
        .i54_FAN_ON      (ct[5]),
        .i59_CA_PS_ACT   (ct[4]),
        .i17_FAN_ON_PERM (ct[3]),
        .i18_FAN_ACT     (ct[2]),
        .i72_I_CA_High   (ct[1]),
        .i76_U_CA_Low    (ct[0]),
        .o19_FAN_ON      (o19),
        .o14_FAN_ON_PERM (o14),
        .o55_Not_Alarm   (o55),
        .o47_CA_ON_PERM  (o47),
        .o62_CA_ON       (o62),
        .o74_CA_Delay    (o74),
        .o75_Not_CA_OK   (o75),
        .o70_I_CA_High   (o70),
        .o77_U_CA_Low    (o77),
        .o78_Modified    (o78)
    );

    typedef struct {
        logic [6:0] st;
        logic [6:0] ct;
        // {o19, o14, o55, o47, o62, o78, o74, o75, o70, o77}
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    vec_t vecs [12];
    sb_t  sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected full output word from the combinational part plus the two timer states.
    function automatic logic [9:0] tmr_exp(input logic [5:0] comb, input logic on4,
                                           input logic on60, input logic i72, input logic i76);
        return {comb, on60, ~(on4 & on60), ~(on4 & i72), ~(on4 & i76)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [9:0] exp, input logic verbose);
        sb_t e;
        sb_q.push_back('{name, exp});
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (w_out === e.exp) begin
            n_pass++;
            if (verbose) $display("check %s: outputs=%b", e.name, w_out);
        end else begin
            $display("FAIL %s: got=%b want=%b", e.name, w_out, e.exp);
        end
    endtask

    initial begin
        vecs[0]  = '{7'b0000000, 7'b0010000, 10'b111001_0111};
        vecs[1]  = '{7'b0000001, 7'b0010000, 10'b110100_0111};
        vecs[2]  = '{7'b1000000, 7'b0000000, 10'b110110_0111};
        vecs[3]  = '{7'b0000000, 7'b1000000, 10'b111110_0111};
        vecs[4]  = '{7'b0000000, 7'b0110000, 10'b111100_0111};
        vecs[5]  = '{7'b0000000, 7'b0011100, 10'b001001_0111};
        vecs[6]  = '{7'b0100000, 7'b0000100, 10'b010110_0111};
        vecs[7]  = '{7'b0000100, 7'b0000000, 10'b110110_0111};
        vecs[8]  = '{7'b1111111, 7'b1111111, 10'b000100_0111};
        vecs[9]  = '{7'b0010000, 7'b0001000, 10'b100110_0111};
        vecs[10] = '{7'b0001000, 7'b0010000, 10'b110100_0111};
        vecs[11] = '{7'b0000010, 7'b0000011, 10'b110110_0111};

        // Combinational table applied while reset is held: outputs must follow inputs anyway.
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            st = vecs[i].st;
            ct = vecs[i].ct;
            chk($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
        end

        // Nominal run: faults clear, CA supply active, i72 high to expose on_4s on o70.
        st = '0;
        ct = 7'b0010010;
        tick();
        chk("reset_state", tmr_exp(6'b111001, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            chk($sformatf("run_k%0d", k), tmr_exp(6'b111001, k >= 15, k >= 75, 1'b1, 1'b0),
                (k == 14 || k == 15 || k == 74 || k == 75));
        end

        // Current/voltage fault gating with on_4s high.
        tick();
        ct = 7'b0010011;
        chk("i72_i76_on4", tmr_exp(6'b111001, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1);

        // One-cycle air-grid fault: cascade restart and full recount.
        tick();
        st = 7'b0100000;
        chk("fault_pulse", tmr_exp(6'b110100, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1);
        tick();
        st = '0;
        chk("fault_p1", tmr_exp(6'b111001, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1);
        for (int k = 2; k <= 80; k++) begin
            tick();
            chk($sformatf("recount_k%0d", k), tmr_exp(6'b111001, k >= 16, k >= 76, 1'b1, 1'b1),
                (k == 2 || k == 16 || k == 76));
        end

        // Supply not active: timers drain and stay at zero.
        tick();
        ct = 7'b0000011;
        chk("i59_low_0", tmr_exp(6'b111011, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1);
        tick();
        chk("i59_low_1", tmr_exp(6'b111011, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1);
        for (int k = 2; k <= 40; k++) begin
            tick();
            chk($sformatf("i59_low_k%0d", k), tmr_exp(6'b111011, 1'b0, 1'b0, 1'b1, 1'b1),
                (k == 2 || k == 40));
        end

        // Reset at count 10 of the 4 s timer restarts the count.
        ct = 7'b0010010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("pre_rst_k%0d", k), tmr_exp(6'b111001, 1'b0, 1'b0, 1'b1, 1'b0),
                (k == 10));
        end
        reset = 1'b1;
        tick();
        chk("mid_reset", tmr_exp(6'b111001, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("post_rst_k%0d", k), tmr_exp(6'b111001, k >= 15, 1'b0, 1'b1, 1'b0),
                (k == 14 || k == 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rpsc_card_1.md
RPSC_CARD_1 -- requirements
Module: rpsc_card_1

Interface
REQ-001 SHALL have parameter: test_mode, default 0, nonzero selects short timer targets for simulation.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have 1-bit status inputs: i51_Card_POS, i50_Air_Grid, i49_Water_Anode, i48_Water_Grid, i46_DC_PS, i45_U_CA_Low, i44_I_CA_High (active-high faults).
REQ-005 SHALL have 1-bit control inputs: i53_Not_G1_OK, i54_FAN_ON, i59_CA_PS_ACT, i17_FAN_ON_PERM, i18_FAN_ACT, i72_I_CA_High, i76_U_CA_Low.
REQ-006 SHALL have 1-bit outputs: o19_FAN_ON, o14_FAN_ON_PERM, o55_Not_Alarm, o47_CA_ON_PERM, o62_CA_ON, o74_CA_Delay, o75_Not_CA_OK, o70_I_CA_High, o77_U_CA_Low, o78_Modified.

Function
REQ-007 SHALL drive o14_FAN_ON_PERM = NOT i17_FAN_ON_PERM and o19_FAN_ON = NOT i18_FAN_ACT, combinationally.
REQ-008 SHALL form norStatus = NOR of the seven status inputs (REQ-004); o55_Not_Alarm = norStatus.
REQ-009 SHALL form norControl = NOR(i53_Not_G1_OK, i54_FAN_ON, NOT norStatus); o78_Modified = norControl; o47_CA_ON_PERM = NOT norControl.
REQ-010 SHALL drive o62_CA_ON = NOT i59_CA_PS_ACT.
REQ-011 SHALL form andControl = norControl AND i59_CA_PS_ACT.
REQ-012 SHALL contain a reusable sub-block timer (parameter WIDTH; ports clk, reset, target[WIDTH-1:0], in, hit_target).
REQ-013 timer SHALL hold an unsigned WIDTH-bit counter: cleared on reset or when in=0; incremented each edge with in=1 and count<target; held (saturated) at target.
REQ-014 timer hit_target SHALL equal (count == target), combinational from the counter, so it rises after exactly target consecutive edges with in=1 and falls on the first edge with in=0.
REQ-015 4 s timer: in=andControl, output on_4s; test_mode=0: WIDTH 22, target 3,125,000 (4 s at 781.25 kHz); test_mode≠0: WIDTH 4, target 15.
REQ-016 SHALL contain sub-block special_60s_timer (parameter test_mode; ports clk, reset, in, hit_target), built on the same counter rules as REQ-013/014.
REQ-017 special_60s_timer: in=on_4s, output on_60s; test_mode=0: WIDTH 26, target 46,875,000 (60 s); test_mode≠0: WIDTH 6, target 60.
REQ-018 SHALL drive o74_CA_Delay = on_60s.
REQ-019 SHALL drive o75_Not_CA_OK = NOT(on_4s AND on_60s).
REQ-020 SHALL drive o70_I_CA_High = NOT(on_4s AND i72_I_CA_High) and o77_U_CA_Low = NOT(on_4s AND i76_U_CA_Low).
REQ-021 Any andControl drop SHALL clear the 4 s counter next edge; on_4s falls, which clears the 60 s counter the following edge (cascade restart from zero).
REQ-022 Counters SHALL never wrap; target is the saturation value.

Reset
REQ-023 On reset both counters SHALL be 0: on_4s=0, on_60s=0, hence o74=0, o75=1, o70=1, o77=1.
REQ-024 Reset SHALL take priority over in; asserting reset mid-count restarts both timers from zero.
REQ-025 Combinational outputs (REQ-007..010) SHALL follow inputs regardless of reset.

Verification (test_mode=1)
REQ-026 All status/control inputs 0, i59=1, reset 1 cycle -> o55=1, o78=1, o47=0, o62=0, o19=1, o14=1; o74=0, o75=1.
REQ-027 Same stimulus -> on_4s rises after 15 edges post-reset; o74 rises 60 edges later; o75 goes 0 at that edge.
REQ-028 With on_4s=1, set i72=1 -> o70=0; i76=1 -> o77=0; both with on_4s=0 -> 1.
REQ-029 After o74=1, pulse i50_Air_Grid=1 one cycle -> o55=0, o47=1, on_4s cleared next edge, on_60s cleared the edge after; full 15+60 recount required.
REQ-030 i59=0 with faults clear -> o62=1, andControl=0, timers stay 0 indefinitely.
REQ-031 Reset asserted at count 10 of the 4 s timer -> on_4s stays 0; rises 15 edges after reset release.
